// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolver: FSM encoding and
// elaboration-time sizing helpers.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int csa_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int csa_idx_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/cpa_chunk.sv
// Combinational CHUNK-bit ripple slice with carry in/out; the resolver
// feeds it one slice of the latched operands per clock.
module cpa_chunk #(
    parameter int CHUNK = 64
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save (sum, carry) pair into binary S + 2*C, rippling the
// carry through one CHUNK-bit slice per clock.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = 320,
    parameter int CHUNK = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [1:0]       out_ovf
);

    localparam int NCHUNK = csa_nchunk(WIDTH, CHUNK);
    localparam int IW     = csa_idx_w(NCHUNK);

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q;
    logic               carry_q;
    logic               c_top_q;
    logic [WIDTH-1:0]   s_q, c_q, sum_q;
    logic [1:0]         ovf_q;
    logic [CHUNK-1:0]   s_sl, c_sl, add_sum;
    logic               add_cout;
    logic               last;
    logic               accept;

    assign accept = (state_q == IDLE) && in_valid;
    assign last   = (idx_q == IW'(NCHUNK - 1));
    assign s_sl   = s_q[int'(idx_q) * CHUNK +: CHUNK];
    assign c_sl   = c_q[int'(idx_q) * CHUNK +: CHUNK];

    cpa_chunk #(.CHUNK(CHUNK)) u_cpa (
        .a    (s_sl),
        .b    (c_sl),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Operand latch: C is pre-shifted so its slices line up with S; the bit
    // shifted out only ever contributes to the overflow field.
    always_ff @(posedge clk) begin
        if (accept) begin
            s_q     <= in_s;
            c_q     <= {in_c[WIDTH-2:0], 1'b0};
            c_top_q <= in_c[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q   <= '0;
                carry_q <= 1'b0;
            end else if (state_q == RUN) begin
                sum_q[int'(idx_q) * CHUNK +: CHUNK] <= add_sum;
                carry_q <= add_cout;
                idx_q   <= idx_q + 1'b1;
                if (last) ovf_q <= {1'b0, add_cout} + {1'b0, c_top_q};
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver: directed and random traffic on a
// WIDTH=16/CHUNK=4 instance plus random traffic on a default-sized instance.
module tb_csa_resolver;

    localparam int SW = 16;
    localparam int SC = 4;
    localparam int BW = 320;
    localparam int BC = 64;

    logic clk = 0;
    always #5 clk = ~clk;

    // small instance
    logic          rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [SW-1:0] in_s = '0, in_c = '0, out_sum;
    logic [1:0]    out_ovf;

    // default-size instance
    logic          rst_n_b = 0, in_valid_b = 0, in_ready_b, out_valid_b, out_ready_b = 0;
    logic [BW-1:0] in_s_b = '0, in_c_b = '0, out_sum_b;
    logic [1:0]    out_ovf_b;

    csa_resolver #(.WIDTH(SW), .CHUNK(SC)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_c(in_c), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    csa_resolver #(.WIDTH(BW), .CHUNK(BC)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_s(in_s_b), .in_c(in_c_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_sum(out_sum_b), .out_ovf(out_ovf_b)
    );

    int total = 0;
    int bad   = 0;
    logic [SW+1:0] q_s[$];
    logic [BW+1:0] q_b[$];
    bit rdy_rand = 0;
    bit done_b   = 0;

    task automatic chk(input string nm, input logic [BW+1:0] act, input logic [BW+1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: full-precision value of S + 2*C.
    function automatic logic [SW+1:0] model_s(input logic [SW-1:0] s, input logic [SW-1:0] c);
        return {2'b00, s} + ({2'b00, c} * 2);
    endfunction

    function automatic logic [BW+1:0] model_b(input logic [BW-1:0] s, input logic [BW-1:0] c);
        return {2'b00, s} + ({2'b00, c} * 2);
    endfunction

    // Monitors: a handshake seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q_s.size() == 0) chk("small_unexpected_output", 1, 0);
            else chk("small_result", {out_ovf, out_sum}, q_s.pop_front());
        end
        if (rst_n_b && out_valid_b && out_ready_b) begin
            if (q_b.size() == 0) chk("big_unexpected_output", 1, 0);
            else chk("big_result", {out_ovf_b, out_sum_b}, q_b.pop_front());
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
            out_ready_b = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send_s(input logic [SW-1:0] s, input logic [SW-1:0] c, input bit push);
        int n = 0;
        in_valid = 1; in_s = s; in_c = c;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) chk("small_accept_timeout", 0, 1);
        else if (push) q_s.push_back(model_s(s, c));
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain_s();
        int n = 0;
        while ((q_s.size() != 0 || out_valid) && n < 2000) begin @(posedge clk); #1; n++; end
        if (q_s.size() != 0) chk("small_drain_timeout", BW'(q_s.size()), 0);
    endtask

    initial begin
        logic [SW-1:0] hold_sum;
        logic [1:0]    hold_ovf;
        int            n;

        @(posedge clk); #1; @(posedge clk); #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_sum", out_sum, 0);
        chk("reset_out_ovf", out_ovf, 0);
        rst_n = 1;
        out_ready = 1;

        // basic pattern and latency
        send_s(16'h00FF, 16'h0001, 1);
        chk("accept_in_ready_low", in_ready, 0);
        for (int k = 1; k <= SC; k++) begin
            @(posedge clk); #1;
            chk($sformatf("latency_out_valid_e%0d", k), out_valid, (k == SC) ? 1 : 0);
        end
        drain_s();
        chk("basic_sum_value", out_sum, 16'h0101);

        send_s(16'hFFFF, 16'h0001, 1);
        drain_s();
        send_s(16'hFFFF, 16'hFFFF, 1);
        drain_s();

        // backpressure
        out_ready = 0;
        send_s(16'h1111, 16'h0222, 1);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_reached_done", out_valid, 1);
        hold_sum = out_sum;
        hold_ovf = out_ovf;
        chk("bp_sum_value", out_sum, 16'h1555);
        in_valid = 1; in_s = 16'hABCD; in_c = 16'h8421;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("bp_sum_stable", out_sum, hold_sum);
            chk("bp_ovf_stable", out_ovf, hold_ovf);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid_held", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1;
        @(negedge clk);
        chk("bp_in_ready_at_handshake", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_in_ready_after_handshake", in_ready, 1);
        if (in_ready) q_s.push_back(model_s(16'hABCD, 16'h8421));
        @(posedge clk); #1;
        in_valid = 0;
        chk("bp_second_accepted", in_ready, 0);
        drain_s();

        // reset while RUN at idx=2
        send_s(16'h5A5A, 16'h0F0F, 0);
        @(posedge clk); #1; @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_sum", out_sum, 0);
        chk("midrst_out_ovf", out_ovf, 0);
        send_s(16'h1234, 16'h0001, 1);
        drain_s();
        chk("post_reset_sum", out_sum, 16'h1236);

        // random traffic with random stalls
        rdy_rand = 1;
        for (int i = 0; i < 1000; i++) begin
            send_s(SW'($urandom), SW'($urandom), 1);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rdy_rand = 0;
        out_ready = 1;
        drain_s();

        n = 0;
        while (!done_b && n < 20000) begin @(posedge clk); #1; n++; end
        chk("big_instance_finished", done_b, 1);
        chk("small_queue_empty", BW'(q_s.size()), 0);
        chk("big_queue_empty", BW'(q_b.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // default-size instance: random pairs including full-ripple corners
    initial begin
        logic [BW-1:0] s, c;
        int n;
        @(posedge clk); #1; @(posedge clk); #1;
        rst_n_b = 1;
        for (int i = 0; i < 150; i++) begin
            for (int j = 0; j < BW / 32; j++) begin
                s[j*32 +: 32] = $urandom;
                c[j*32 +: 32] = $urandom;
            end
            if (i == 0) begin s = '1; c = BW'(1); end
            if (i == 1) begin s = '1; c = '1; end
            in_valid_b = 1; in_s_b = s; in_c_b = c;
            n = 0;
            @(negedge clk);
            while (!in_ready_b && n < 200) begin @(negedge clk); n++; end
            if (!in_ready_b) chk("big_accept_timeout", 0, 1);
            else q_b.push_back(model_b(s, c));
            @(posedge clk); #1;
            in_valid_b = 0;
        end
        n = 0;
        while (q_b.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
        done_b = 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
